imem_responder: RTL
===================

Name: imem_responder

Overview:
- Word-addressed instruction memory that serves the fetch stage as the responder side of a fetch request/response handshake.
- Accepts one word-index address per cycle and returns the 32-bit instruction through a 2-entry response buffer that absorbs backpressure.
- Provides a single-word load port so a bench or boot loader can write program words.
- After every reset, a clear sequencer zeroes the whole array before any request is accepted.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, at least 2.
- ADDR_W, 32, width of the request and load address ports; addresses are word indices (PC increments by 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_addr  in  ADDR_W  word index to read.
- rsp_valid  out  1  response buffer head is valid.
- rsp_ready  in  1  consumer takes the head this cycle.
- rsp_instr  out  32  instruction word at the buffer head.
- rsp_err  out  1  head came from an address ≥ DEPTH.
- ld_en  in  1  write ld_data to ld_addr this cycle.
- ld_addr  in  ADDR_W  load word index.
- ld_data  in  32  load data.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to CLEAR and clr_idx goes to 0.
  - Response buffer is emptied; any in-flight responses are discarded.
  - Registered outputs after reset: rsp_valid=0, rsp_instr=0, rsp_err=0, busy=1, req_ready=0.
  - Reset asserted mid-clear or mid-stream restarts the clear from index 0.
- CLEAR state:
  - Each cycle writes 0 to mem[clr_idx], then increments clr_idx.
  - After the write to index DEPTH-1, the next state is RUN.
  - Exactly DEPTH cycles are spent in CLEAR; busy is low from the first RUN cycle.
  - During CLEAR: req_ready=0 and ld_en is ignored (no write, no error flag).
- RUN state: remains in RUN until the next reset.
- Request acceptance:
  - req_ready = (state==RUN) && (count<2), where count is the buffer occupancy (0..2).
  - req_ready is a function of registered state only; it has no combinational path from rsp_ready or req_valid.
- Read latency:
  - A request accepted at edge E pushes {mem[req_addr], err=0} into the buffer at E.
  - rsp_valid is high in the cycle following E if the buffer was empty.
  - If req_addr ≥ DEPTH, the pushed entry is {0, err=1} and memory is not touched.
- Response buffer:
  - 2-entry FIFO, in-order; pop when rsp_valid && rsp_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Full throughput of one response per cycle is sustained while rsp_ready stays high.
  - The head entry is held stable while rsp_valid=1 and rsp_ready=0.
  - rsp_instr and rsp_err are 0 when the buffer is empty.
- Load port (RUN only):
  - On ld_en, mem[ld_addr] <= ld_data at the edge.
  - If ld_addr ≥ DEPTH, the write is dropped silently.
- Read and load to the same address in the same cycle: the response returns the old word (read-before-write); the new word is visible to the next request.
- Address width: only the low log2(DEPTH) bits index the array; the range check uses the full ADDR_W value.

Decomposition:
- Package imem_pkg holds:
  - state typedef {CLEAR, RUN};
  - response entry struct {instr[31:0], err};
  - constant INSTR_W=32 and constant NOP_WORD=0.
- One sub-module, imem_rsp_fifo: 2-entry FIFO with push/pop/count, synchronous active-low reset, exposing count for req_ready.

Test Plan:
- Release reset → busy=1 for exactly DEPTH=16 cycles, req_ready=0 throughout, then busy=0 and req_ready=1; a read of addr 5 returns 0x00000000 with err=0.
- Load addr 3 = 0xDEADBEEF and addr 4 = 0x00000013, then request 3 and then 4 back-to-back with rsp_ready=1 → responses 0xDEADBEEF then 0x00000013 on consecutive cycles, each one cycle after its accept.
- Hold rsp_ready=0 and issue 3 requests (addrs 0,1,2) → first two accepted, req_ready drops with count=2, and the head (addr 0) is held stable. Raise rsp_ready → in-order drain; addr 2 is accepted only once count<2.
- Request addr 16 with DEPTH=16 → rsp_instr=0, rsp_err=1; ld_en to addr 20 → no array change (re-read addrs 4 and 0 unchanged).
- Same cycle: read addr 7 (holding 0x11111111) and load addr 7 = 0x22222222 → response 0x11111111; the next read of addr 7 returns 0x22222222.
- Assert rst for one cycle while two responses are buffered and mid-stream → rsp_valid=0 on the next cycle, busy=1, and the clear restarts at 0 (previously loaded word reads 0 after the clear completes).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory responder.
package imem_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               err;
    } rsp_entry_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry in-order response buffer; slot0 is always the head.
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  rsp_entry_t push_data_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    rsp_entry_t slot0_q, slot0_d;
    rsp_entry_t slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_push = push_i && (count_q != 2'd2);
        do_pop  = pop_i && (count_q != 2'd0);
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_data_i;
                end else begin
                    slot1_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // Empty slots are kept zero so the head reads as zero when drained.
                slot0_d = slot1_q;
                slot1_d = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                slot0_d = push_data_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/imem_responder.sv
// Word-addressed instruction memory with a load port, a post-reset clear sequencer
// and a two-entry response buffer on the fetch side.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_err,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               busy_q, busy_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [INSTR_W-1:0] mem_wdata;

    rsp_entry_t         rd_entry, rsp_head;
    logic [1:0]         rsp_count;
    logic               push, pop;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr[IDX_W-1:0];
        mem_wdata = ld_data;
        case (state_q)
            CLEAR: begin
                mem_we    = rst;
                mem_waddr = clr_idx_q;
                mem_wdata = NOP_WORD;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = rst && ld_en && (ld_addr < DEPTH_A);
            end
            default: ;
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Array contents are not reset; the clear sequencer zeroes them instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_entry.err   = (req_addr >= DEPTH_A);
        rd_entry.instr = rd_entry.err ? NOP_WORD : mem_q[req_addr[IDX_W-1:0]];
    end

    assign req_ready = (state_q == RUN) && (rsp_count < 2'd2);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    imem_rsp_fifo u_rsp_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (push),
        .push_data_i (rd_entry),
        .pop_i       (pop),
        .head_o      (rsp_head),
        .valid_o     (rsp_valid),
        .count_o     (rsp_count)
    );

    assign rsp_instr = rsp_valid ? rsp_head.instr : NOP_WORD;
    assign rsp_err   = rsp_valid && rsp_head.err;
    assign busy      = busy_q;

endmodule
